message_interpreter_mb: RTL and testbench

Parametrised command interpreter between the UART RX/TX byte interface and the robot core. It decodes single-byte host commands into waypoint select and active-low stop/begin controls. Telemetry requests are answered with multi-byte framed replies: a header byte, the full N_WIDTH-bit channel word MSB-first, then an XOR checksum. Replies use a valid/ready handshake toward the UART transmitter, and one further request can be buffered behind the frame in flight.

---
 rtl/message_interpreter_mb.sv | 183 ++++++++++++++++++
 tb/tb_message_interpreter_mb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/message_interpreter_mb.sv
// Host command interpreter: decodes single-byte commands into waypoint/stop/begin
// controls and streams framed telemetry replies (header, word MSB-first, XOR checksum).
module message_interpreter_mb #(
  parameter int N_WIDTH = 32,
  parameter int N_CHANNELS = 16,
  parameter int N_WAYPOINTS = 8,
  localparam int WAY_WIDTH = $clog2(N_WAYPOINTS),
  localparam int NBYTES = N_WIDTH / 8
) (
  input  logic                           MESSAGE_INTERPRETER_MB_CLOCK_50,
  input  logic                           MESSAGE_INTERPRETER_MB_RESET_InHigh,
  input  logic                           MESSAGE_INTERPRETER_MB_FLAGDATAIN_In,
  input  logic [7:0]                     MESSAGE_INTERPRETER_MB_DATAIN_InBus,
  input  logic [N_CHANNELS*N_WIDTH-1:0]  MESSAGE_INTERPRETER_MB_CHANNELS_InBus,
  output logic [7:0]                     MESSAGE_INTERPRETER_MB_TXDATA_OutBus,
  output logic                           MESSAGE_INTERPRETER_MB_TXVALID_Out,
  input  logic                           MESSAGE_INTERPRETER_MB_TXREADY_In,
  output logic [WAY_WIDTH-1:0]           MESSAGE_INTERPRETER_MB_WAYSELECT_OutBus,
  output logic                           MESSAGE_INTERPRETER_MB_STOPSIGNAL_OutLow,
  output logic                           MESSAGE_INTERPRETER_MB_BEGINSIGNAL_OutLow,
  output logic                           MESSAGE_INTERPRETER_MB_BUSY_Out,
  output logic [7:0]                     MESSAGE_INTERPRETER_MB_ERRCOUNT_OutBus,
  output logic [7:0]                     MESSAGE_INTERPRETER_MB_DROPCOUNT_OutBus
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEADER = 2'd1, ST_DATA = 2'd2, ST_CHECK = 2'd3} txState_t;

  txState_t              state_r, stateNext_s;
  logic [IDXW-1:0]       idx_r, idxNext_s;
  logic [5:0]            activeChan_r, activeChanNext_s, pendChan_r, pendChanNext_s, reqChan_s;
  logic [N_WIDTH-1:0]    activeWord_r, activeWordNext_s, pendWord_r, pendWordNext_s, reqWord_s;
  logic                  pendValid_r, pendValidNext_s;
  logic [WAY_WIDTH-1:0]  way_r, wayNext_s;
  logic                  stop_r, stopNext_s, begin_r, beginNext_s;
  logic [7:0]            errCount_r, errNext_s, dropCount_r, dropNext_s;
  logic [7:0]            txData_r, txDataNext_s;
  logic                  txValid_r, txValidNext_s, busy_r, busyNext_s;
  logic                  isWay_s, isStop_s, isBegin_s, isReq_s, isErr_s, reqDirect_s, hs_s;
  logic [7:0]            code_s;

  function automatic logic [7:0] pickByte(input logic [N_WIDTH-1:0] word, input logic [IDXW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      b = (idx == IDXW'(i)) ? word[(NBYTES-1-i)*8 +: 8] : b;
    end
    return b;
  endfunction

  function automatic logic [7:0] frameChecksum(input logic [5:0] chan, input logic [N_WIDTH-1:0] word);
    logic [7:0] c;
    c = {2'b10, chan};
    for (int i = 0; i < NBYTES; i++) begin
      c = c ^ word[i*8 +: 8];
    end
    return c;
  endfunction

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign code_s = MESSAGE_INTERPRETER_MB_DATAIN_InBus;
  assign hs_s   = txValid_r & MESSAGE_INTERPRETER_MB_TXREADY_In;

  // Command classification and channel snapshot mux
  always_comb begin
    isWay_s = 1'b0; isStop_s = 1'b0; isBegin_s = 1'b0; isReq_s = 1'b0; isErr_s = 1'b0;
    reqChan_s = code_s[5:0];
    reqWord_s = '0;
    if (MESSAGE_INTERPRETER_MB_FLAGDATAIN_In) begin
      if (code_s >= 8'd1 && code_s <= 8'(N_WAYPOINTS)) isWay_s = 1'b1;
      else if (code_s == 8'hF0) isStop_s = 1'b1;
      else if (code_s == 8'hF1) isBegin_s = 1'b1;
      else if (code_s[7] && ({1'b0, code_s[6:0]} < 8'(N_CHANNELS))) isReq_s = 1'b1;
      else isErr_s = 1'b1;
    end else begin
      isErr_s = 1'b0;
    end
    for (int c = 0; c < N_CHANNELS; c++) begin
      reqWord_s = (reqChan_s == 6'(c)) ? MESSAGE_INTERPRETER_MB_CHANNELS_InBus[c*N_WIDTH +: N_WIDTH] : reqWord_s;
    end
  end

  // Next-state: transmit FSM, request routing, controls and counters
  always_comb begin
    stateNext_s = state_r; idxNext_s = idx_r;
    activeChanNext_s = activeChan_r; activeWordNext_s = activeWord_r;
    pendValidNext_s = pendValid_r; pendChanNext_s = pendChan_r; pendWordNext_s = pendWord_r;
    wayNext_s = way_r; stopNext_s = stop_r; beginNext_s = begin_r;
    errNext_s = errCount_r; dropNext_s = dropCount_r;
    reqDirect_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (isReq_s) begin stateNext_s = ST_HEADER; reqDirect_s = 1'b1; end
        else stateNext_s = ST_IDLE;
      end
      ST_HEADER: begin
        if (hs_s) begin stateNext_s = ST_DATA; idxNext_s = '0; end
        else stateNext_s = ST_HEADER;
      end
      ST_DATA: begin
        if (hs_s && idx_r == LAST_IDX) stateNext_s = ST_CHECK;
        else if (hs_s) idxNext_s = idx_r + IDXW'(1);
        else stateNext_s = ST_DATA;
      end
      ST_CHECK: begin
        if (hs_s && pendValid_r) begin
          stateNext_s = ST_HEADER;
          activeChanNext_s = pendChan_r;
          activeWordNext_s = pendWord_r;
          pendValidNext_s = 1'b0;
        end else if (hs_s && isReq_s) begin
          // slot empty and frame finishing: start the new frame without a gap
          stateNext_s = ST_HEADER; reqDirect_s = 1'b1;
        end else if (hs_s) stateNext_s = ST_IDLE;
        else stateNext_s = ST_CHECK;
      end
      default: stateNext_s = ST_IDLE;
    endcase
    // pendValid_r is the pre-edge view, so a draining slot still drops
    if (reqDirect_s) begin
      activeChanNext_s = reqChan_s; activeWordNext_s = reqWord_s;
    end else if (isReq_s && pendValid_r) dropNext_s = satInc(dropCount_r);
    else if (isReq_s) begin
      pendValidNext_s = 1'b1; pendChanNext_s = reqChan_s; pendWordNext_s = reqWord_s;
    end else dropNext_s = dropCount_r;
    if (isWay_s) begin
      wayNext_s = WAY_WIDTH'(code_s - 8'd1); stopNext_s = 1'b1; beginNext_s = 1'b1;
    end else if (isStop_s) begin
      wayNext_s = '0; stopNext_s = 1'b0; beginNext_s = 1'b1;
    end else if (isBegin_s) begin
      wayNext_s = '0; stopNext_s = 1'b1; beginNext_s = 1'b0;
    end else if (isErr_s) errNext_s = satInc(errCount_r);
    else errNext_s = errCount_r;
  end

  // Output decode from the next state so the reply byte leaves a register
  always_comb begin
    txValidNext_s = 1'b0;
    txDataNext_s = 8'h00;
    case (stateNext_s)
      ST_IDLE:   begin txValidNext_s = 1'b0; txDataNext_s = 8'h00; end
      ST_HEADER: begin txValidNext_s = 1'b1; txDataNext_s = {2'b10, activeChanNext_s}; end
      ST_DATA:   begin txValidNext_s = 1'b1; txDataNext_s = pickByte(activeWordNext_s, idxNext_s); end
      ST_CHECK:  begin txValidNext_s = 1'b1; txDataNext_s = frameChecksum(activeChanNext_s, activeWordNext_s); end
      default:   begin txValidNext_s = 1'b0; txDataNext_s = 8'h00; end
    endcase
    busyNext_s = (stateNext_s != ST_IDLE) || pendValidNext_s;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge MESSAGE_INTERPRETER_MB_CLOCK_50) begin
    if (MESSAGE_INTERPRETER_MB_RESET_InHigh) begin
      state_r <= ST_IDLE; idx_r <= '0;
      activeChan_r <= 6'd0; activeWord_r <= '0;
      pendValid_r <= 1'b0; pendChan_r <= 6'd0; pendWord_r <= '0;
      way_r <= '0; stop_r <= 1'b0; begin_r <= 1'b1;
      errCount_r <= 8'd0; dropCount_r <= 8'd0;
      txData_r <= 8'h00; txValid_r <= 1'b0; busy_r <= 1'b0;
    end else begin
      state_r <= stateNext_s; idx_r <= idxNext_s;
      activeChan_r <= activeChanNext_s; activeWord_r <= activeWordNext_s;
      pendValid_r <= pendValidNext_s; pendChan_r <= pendChanNext_s; pendWord_r <= pendWordNext_s;
      way_r <= wayNext_s; stop_r <= stopNext_s; begin_r <= beginNext_s;
      errCount_r <= errNext_s; dropCount_r <= dropNext_s;
      txData_r <= txDataNext_s; txValid_r <= txValidNext_s; busy_r <= busyNext_s;
    end
  end

  assign MESSAGE_INTERPRETER_MB_TXDATA_OutBus     = txData_r;
  assign MESSAGE_INTERPRETER_MB_TXVALID_Out       = txValid_r;
  assign MESSAGE_INTERPRETER_MB_WAYSELECT_OutBus  = way_r;
  assign MESSAGE_INTERPRETER_MB_STOPSIGNAL_OutLow  = stop_r;
  assign MESSAGE_INTERPRETER_MB_BEGINSIGNAL_OutLow = begin_r;
  assign MESSAGE_INTERPRETER_MB_BUSY_Out          = busy_r;
  assign MESSAGE_INTERPRETER_MB_ERRCOUNT_OutBus   = errCount_r;
  assign MESSAGE_INTERPRETER_MB_DROPCOUNT_OutBus  = dropCount_r;

endmodule

// File: tb/tb_message_interpreter_mb.sv
// Bench for message_interpreter_mb: directed steps plus random soak against a
// queue-based reference model of outstanding frames and reply bytes.
module tb_message_interpreter_mb;

  localparam int NW = 32;
  localparam int NC = 16;
  localparam int NWP = 8;
  localparam int NB = NW / 8;

  logic clk, rst, flag, txReady;
  logic [7:0] dataIn;
  logic [NC*NW-1:0] chanBus;
  logic [7:0] txData, errCnt, dropCnt;
  logic txValid, stopN, beginN, busy;
  logic [2:0] waySel;

  message_interpreter_mb #(.N_WIDTH(NW), .N_CHANNELS(NC), .N_WAYPOINTS(NWP)) dut (
    .MESSAGE_INTERPRETER_MB_CLOCK_50(clk),
    .MESSAGE_INTERPRETER_MB_RESET_InHigh(rst),
    .MESSAGE_INTERPRETER_MB_FLAGDATAIN_In(flag),
    .MESSAGE_INTERPRETER_MB_DATAIN_InBus(dataIn),
    .MESSAGE_INTERPRETER_MB_CHANNELS_InBus(chanBus),
    .MESSAGE_INTERPRETER_MB_TXDATA_OutBus(txData),
    .MESSAGE_INTERPRETER_MB_TXVALID_Out(txValid),
    .MESSAGE_INTERPRETER_MB_TXREADY_In(txReady),
    .MESSAGE_INTERPRETER_MB_WAYSELECT_OutBus(waySel),
    .MESSAGE_INTERPRETER_MB_STOPSIGNAL_OutLow(stopN),
    .MESSAGE_INTERPRETER_MB_BEGINSIGNAL_OutLow(beginN),
    .MESSAGE_INTERPRETER_MB_BUSY_Out(busy),
    .MESSAGE_INTERPRETER_MB_ERRCOUNT_OutBus(errCnt),
    .MESSAGE_INTERPRETER_MB_DROPCOUNT_OutBus(dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: queued reply bytes and per-frame remaining byte counts
  logic [7:0] expQ[$];
  int frameLeft[$];
  logic [2:0] mWay;
  logic mStop, mBegin;
  int mErr, mDrop;
  logic capture;
  logic [7:0] capQ[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] getChan(input int k);
    return chanBus[k*NW +: NW];
  endfunction

  function automatic bit isValidCode(input logic [7:0] c);
    return (c >= 8'd1 && c <= 8'(NWP)) || c == 8'hF0 || c == 8'hF1 ||
           (c >= 8'h80 && int'(c) - 128 < NC);
  endfunction

  task automatic pushFrame(input int k);
    logic [NW-1:0] w;
    logic [7:0] cs, b;
    w = getChan(k);
    cs = 8'(128 + k);
    expQ.push_back(cs);
    for (int i = NB - 1; i >= 0; i--) begin
      b = w[i*8 +: 8];
      expQ.push_back(b);
      cs = cs ^ b;
    end
    expQ.push_back(cs);
    frameLeft.push_back(NB + 2);
  endtask

  task automatic checkOutputs();
    chk("txvalid", {63'd0, txValid}, {63'd0, expQ.size() > 0});
    if (expQ.size() > 0) chk("txdata", {56'd0, txData}, {56'd0, expQ[0]});
    chk("busy", {63'd0, busy}, {63'd0, frameLeft.size() > 0});
    chk("waysel", {61'd0, waySel}, {61'd0, mWay});
    chk("stop", {63'd0, stopN}, {63'd0, mStop});
    chk("begin", {63'd0, beginN}, {63'd0, mBegin});
    chk("errcount", {56'd0, errCnt}, 64'(mErr));
    chk("dropcount", {56'd0, dropCnt}, 64'(mDrop));
  endtask

  // one clock cycle: drive at negedge, check, advance model at posedge
  task automatic step(input logic r, input logic f, input logic [7:0] d, input logic rdy);
    bit hs;
    int size0;
    rst = r; flag = f; dataIn = d; txReady = rdy;
    #1;
    checkOutputs();
    hs = rdy && (expQ.size() > 0);
    size0 = frameLeft.size();
    if (capture && txValid === 1'b1 && rdy) capQ.push_back(txData);
    @(posedge clk);
    if (r) begin
      expQ.delete(); frameLeft.delete();
      mWay = 3'd0; mStop = 1'b0; mBegin = 1'b1; mErr = 0; mDrop = 0;
    end else begin
      if (f) begin
        if (d >= 8'd1 && d <= 8'(NWP)) begin
          mWay = 3'(d - 8'd1); mStop = 1'b1; mBegin = 1'b1;
        end else if (d == 8'hF0) begin
          mWay = 3'd0; mStop = 1'b0; mBegin = 1'b1;
        end else if (d == 8'hF1) begin
          mWay = 3'd0; mStop = 1'b1; mBegin = 1'b0;
        end else if (d >= 8'h80 && int'(d) - 128 < NC) begin
          if (size0 < 2) pushFrame(int'(d) - 128);
          else mDrop = (mDrop < 255) ? mDrop + 1 : 255;
        end else mErr = (mErr < 255) ? mErr + 1 : 255;
      end
      if (hs) begin
        void'(expQ.pop_front());
        frameLeft[0] = frameLeft[0] - 1;
        if (frameLeft[0] == 0) void'(frameLeft.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic checkFrame83(input string tag);
    logic [7:0] ref83 [6];
    ref83 = '{8'h83, 8'h12, 8'h34, 8'h56, 8'h78, 8'h8B};
    chk({tag, "_len"}, 64'(capQ.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < capQ.size()) chk($sformatf("%s_b%0d", tag, i), {56'd0, capQ[i]}, {56'd0, ref83[i]});
    end
  endtask

  initial begin
    logic [7:0] c;
    logic [2:0] holdWay;
    logic holdStop, holdBegin;
    int sel;
    rst = 1'b1; flag = 1'b0; dataIn = 8'h00; txReady = 1'b0; capture = 1'b0;
    mWay = 3'd0; mStop = 1'b0; mBegin = 1'b1; mErr = 0; mDrop = 0;
    for (int k = 0; k < NC; k++) chanBus[k*NW +: NW] = $urandom();
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_txdata", {56'd0, txData}, 64'd0);
    chk("rst_txvalid", {63'd0, txValid}, 64'd0);
    chk("rst_stop", {63'd0, stopN}, 64'd0);
    chk("rst_begin", {63'd0, beginN}, 64'd1);

    step(1'b0, 1'b1, 8'h05, 1'b0);
    chk("way5_sel", {61'd0, waySel}, 64'd4);
    chk("way5_stop", {63'd0, stopN}, 64'd1);
    step(1'b0, 1'b1, 8'hF0, 1'b0);
    chk("f0_stop", {63'd0, stopN}, 64'd0);
    chk("f0_way", {61'd0, waySel}, 64'd0);
    step(1'b0, 1'b1, 8'hF1, 1'b0);
    chk("f1_begin", {63'd0, beginN}, 64'd0);
    chk("f1_stop", {63'd0, stopN}, 64'd1);

    // basic frame, ready held high
    chanBus[3*NW +: NW] = 32'h12345678;
    capQ.delete(); capture = 1'b1;
    step(1'b0, 1'b1, 8'h83, 1'b1);
    repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1);
    capture = 1'b0;
    checkFrame83("frame83");
    chk("frame83_idle_valid", {63'd0, txValid}, 64'd0);
    chk("frame83_idle_busy", {63'd0, busy}, 64'd0);

    // same frame under random backpressure, channel changes mid-frame
    capQ.delete(); capture = 1'b1;
    step(1'b0, 1'b1, 8'h83, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 60; i++) begin
      if (i == 3) chanBus[3*NW +: NW] = $urandom();
      step(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
    end
    repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1);
    capture = 1'b0;
    chanBus[3*NW +: NW] = 32'h12345678;
    checkFrame83("frame83_bp");

    // queue one request, drop the next
    step(1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b1, 8'h82, 1'b0);
    step(1'b0, 1'b1, 8'h84, 1'b0);
    chk("drop_one", {56'd0, dropCnt}, 64'd1);
    capQ.delete(); capture = 1'b1;
    repeat (16) step(1'b0, 1'b0, 8'h00, 1'b1);
    capture = 1'b0;
    chk("b2b_len", 64'(capQ.size()), 64'(2 * (NB + 2)));
    if (capQ.size() > NB + 2) chk("b2b_hdr2", {56'd0, capQ[NB+2]}, 64'h82);

    // invalid codes saturate the error counter without touching controls
    holdWay = waySel; holdStop = stopN; holdBegin = beginN;
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h09, 1'b1);
    step(1'b0, 1'b1, 8'(128 + NC), 1'b1);
    for (int i = 0; i < 300; i++) begin
      c = 8'($urandom_range(0, 255));
      while (isValidCode(c)) c = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, c, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("err_sat", {56'd0, errCnt}, 64'd255);
    chk("err_way_hold", {61'd0, waySel}, {61'd0, holdWay});
    chk("err_stop_hold", {63'd0, stopN}, {63'd0, holdStop});
    chk("err_begin_hold", {63'd0, beginN}, {63'd0, holdBegin});

    // reset in DATA with a request pending
    step(1'b0, 1'b1, 8'h83, 1'b1);
    step(1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("midrst_valid", {63'd0, txValid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_stop", {63'd0, stopN}, 64'd0);
    capQ.delete(); capture = 1'b1;
    step(1'b0, 1'b1, 8'h83, 1'b1);
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
    capture = 1'b0;
    checkFrame83("postrst");

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) chanBus[$urandom_range(0, NC-1)*NW +: NW] = $urandom();
      sel = $urandom_range(0, 9);
      if (sel < 4) c = 8'h00;
      else if (sel == 4) c = 8'($urandom_range(1, NWP));
      else if (sel == 5) c = 8'($urandom_range(8'hF0, 8'hF1));
      else if (sel < 9) c = 8'(128 + $urandom_range(0, NC + 1));
      else c = 8'($urandom_range(0, 255));
      step(1'b0, sel >= 4, c, $urandom_range(0, 9) < 7);
    end
    repeat (40) step(1'b0, 1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
